// File: rtl/mix_columns_seq.sv
// mix_columns_seq
// Iterative AES MixColumns / InvMixColumns engine. It accepts one 128-bit
// state from the ShiftRows stage and transforms one 32-bit column per clock.
// It then presents the result to the AddRoundKey stage. The engine holds only
// one block at a time.
//
// Ports:
//   clk      system clock, every register updates on the rising edge
//   n_rst    synchronous active-low reset
//   i_state  input state, byte k = i_state[127-8k -: 8], column c = bytes 4c..4c+3
//   i_inv    0 = MixColumns, 1 = InvMixColumns, captured together with i_state
//   i_valid  upstream offers a state
//   o_ready  engine can accept a state (IDLE only)
//   o_state  result state, same byte ordering as i_state
//   o_valid  o_state holds a complete result
//   i_ready  downstream takes o_state
module mix_columns_seq #(
  parameter int NUM_COLS = 4
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic [127:0] i_state,
  input  logic         i_inv,
  input  logic         i_valid,
  output logic         o_ready,
  output logic [127:0] o_state,
  output logic         o_valid,
  input  logic         i_ready
);

  localparam int CW = $clog2(NUM_COLS);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [127:0]    data_q;
  logic            inv_q;
  logic [31:0]     col_in;
  logic [31:0]     col_out;

  // Multiply by x in GF(2^8), reducing with the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Constant multiply: XOR of the xtime chain picked by the constant's set bits.
  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [7:0] k);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = b;
    for (int i = 0; i < 8; i++) begin
      if (k[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // Output byte r is the XOR over j of coeff[(j-r) mod 4] * a_j, so each row
  // sees the coefficient vector rotated by its own index.
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [7:0] a     [4];
    logic [7:0] coeff [4];
    logic [7:0] acc;
    logic [31:0] res;
    if (inv) begin
      coeff[0] = 8'h0e; coeff[1] = 8'h0b; coeff[2] = 8'h0d; coeff[3] = 8'h09;
    end else begin
      coeff[0] = 8'h02; coeff[1] = 8'h03; coeff[2] = 8'h01; coeff[3] = 8'h01;
    end
    for (int j = 0; j < 4; j++) a[j] = col[31-8*j -: 8];
    res = 32'h0;
    for (int r = 0; r < 4; r++) begin
      acc = 8'h00;
      for (int j = 0; j < 4; j++) acc = acc ^ gmul(a[j], coeff[(j - r + 4) % 4]);
      res[31-8*r -: 8] = acc;
    end
    return res;
  endfunction

  assign o_ready = (state == IDLE);

  // Pick the column addressed by the counter out of the captured block.
  always_comb begin
    col_in = 32'h0;
    for (int c = 0; c < NUM_COLS; c++) begin
      if (cnt == CW'(c)) col_in = data_q[127-32*c -: 32];
    end
  end

  assign col_out = mix_col(col_in, inv_q);

  // Main control: capture in IDLE, one column per edge in BUSY, then hold the
  // result in DONE until downstream takes it. Going to IDLE after the output
  // handshake keeps the two handshakes from happening on the same edge.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      o_valid <= 1'b0;
      o_state <= 128'h0;
      data_q  <= 128'h0;
      inv_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            data_q <= i_state;
            inv_q  <= i_inv;
            cnt    <= '0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          for (int c = 0; c < NUM_COLS; c++) begin
            if (cnt == CW'(c)) o_state[127-32*c -: 32] <= col_out;
          end
          if (cnt == CW'(NUM_COLS - 1)) begin
            cnt     <= '0;
            state   <= DONE;
            o_valid <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (i_ready) begin
            state   <= IDLE;
            o_valid <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mix_columns_seq.sv
// tb_mix_columns_seq
// Scoreboard bench for mix_columns_seq. Each issued block pushes its expected
// result into a queue. A separate monitor pops an entry and compares it
// whenever the DUT completes an output handshake. Random blocks are checked
// against a reference model that does full carry-less multiplication followed
// by polynomial reduction.
module tb_mix_columns_seq;

  logic         clk = 1'b0;
  logic         n_rst;
  logic [127:0] i_state;
  logic         i_inv;
  logic         i_valid;
  logic         o_ready;
  logic [127:0] o_state;
  logic         o_valid;
  logic         i_ready;

  logic [127:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mix_columns_seq #(.NUM_COLS(4)) dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .i_state (i_state),
    .i_inv   (i_inv),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_state (o_state),
    .o_valid (o_valid),
    .i_ready (i_ready)
  );

  // Full polynomial product, then reduction modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul_ref(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = 15'h0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'(9'h11b) << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] mix_ref(input logic [127:0] s, input logic inv);
    logic [7:0] coeff [4];
    logic [7:0] a     [4];
    logic [7:0] acc;
    logic [127:0] r;
    if (inv) begin
      coeff[0] = 8'h0e; coeff[1] = 8'h0b; coeff[2] = 8'h0d; coeff[3] = 8'h09;
    end else begin
      coeff[0] = 8'h02; coeff[1] = 8'h03; coeff[2] = 8'h01; coeff[3] = 8'h01;
    end
    r = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = s[127-8*(4*c+j) -: 8];
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul_ref(a[j], coeff[(j - row + 4) % 4]);
        r[127-8*(4*c+row) -: 8] = acc;
      end
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%h want=%h", name, act, want);
    end
  endtask

  // Monitor: an output handshake happens on the coming edge whenever
  // o_valid and i_ready are both high at the falling edge.
  always @(negedge clk) begin
    if (n_rst === 1'b1 && o_valid === 1'b1 && i_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_output", o_state, 128'h0);
      end else begin
        checkOutput("result", o_state, exp_q.pop_front());
      end
    end
  end

  // Offer one block, scramble the inputs while the engine is busy, and check
  // the accept-to-valid latency. The block completes if i_ready is high.
  task automatic applyStimulus(input logic [127:0] s, input logic inv, input logic [127:0] want);
    int n;
    n = 0;
    while (o_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("accept_ready", 128'(o_ready), 128'd1);
    i_state = s;
    i_inv   = inv;
    i_valid = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(want);
    checkOutput("busy_ready", 128'(o_ready), 128'd0);
    n = 0;
    do begin
      i_valid = 1'($urandom_range(0, 1));
      i_state = {$urandom, $urandom, $urandom, $urandom};
      i_inv   = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end while (o_valid !== 1'b1 && n < 20);
    i_valid = 1'b0;
    checkOutput("latency", 128'(n), 128'd4);
    if (i_ready) begin
      @(posedge clk); #1;
      checkOutput("post_ready", 128'(o_ready), 128'd1);
      checkOutput("post_valid", 128'(o_valid), 128'd0);
    end
  endtask

  initial begin
    logic [127:0] s;
    logic [127:0] bp_exp;
    logic         inv;
    int n;

    n_rst   = 1'b0;
    i_state = 128'h0;
    i_inv   = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid", 128'(o_valid), 128'd0);
    checkOutput("rst_state", o_state, 128'h0);
    n_rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_ready", 128'(o_ready), 128'd1);

    // Known-answer vectors.
    i_ready = 1'b1;
    applyStimulus(128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0,
                  128'h046681e5e0cb199a48f8d37a2806264c);
    applyStimulus(128'h046681e5e0cb199a48f8d37a2806264c, 1'b1,
                  128'hd4bf5d30e0b452aeb84111f11e2798e5);
    applyStimulus(128'hdb135345f20a225c01010101c6c6c6c6, 1'b0,
                  128'h8e4da1bc9fdc589d01010101c6c6c6c6);

    // Random blocks in both directions.
    for (int t = 0; t < 10; t++) begin
      s   = {$urandom, $urandom, $urandom, $urandom};
      inv = 1'($urandom_range(0, 1));
      applyStimulus(s, inv, mix_ref(s, inv));
    end

    // Backpressure: the result must hold while i_valid and i_state wiggle.
    i_ready = 1'b0;
    s = {$urandom, $urandom, $urandom, $urandom};
    bp_exp = mix_ref(s, 1'b1);
    applyStimulus(s, 1'b1, bp_exp);
    for (int t = 0; t < 10; t++) begin
      i_valid = 1'b1;
      i_state = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      checkOutput("bp_state", o_state, bp_exp);
      checkOutput("bp_valid", 128'(o_valid), 128'd1);
      checkOutput("bp_ready", 128'(o_ready), 128'd0);
    end
    s = {$urandom, $urandom, $urandom, $urandom};
    i_state = s;
    i_inv   = 1'b0;
    i_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("hs_valid", 128'(o_valid), 128'd0);
    checkOutput("hs_ready", 128'(o_ready), 128'd1);
    checkOutput("hs_hold", o_state, bp_exp);
    i_ready = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back(mix_ref(s, 1'b0));
    checkOutput("next_accept", 128'(o_ready), 128'd0);
    i_valid = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (o_valid !== 1'b1 && n < 20);
    checkOutput("next_latency", 128'(n), 128'd4);
    i_ready = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of a block aborts it.
    i_state = {$urandom, $urandom, $urandom, $urandom};
    i_inv   = 1'b0;
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("mid_rst_valid", 128'(o_valid), 128'd0);
    checkOutput("mid_rst_state", o_state, 128'h0);
    checkOutput("mid_rst_ready", 128'(o_ready), 128'd1);
    n_rst = 1'b1;
    s = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus(s, 1'b1, mix_ref(s, 1'b1));

    // Drain the scoreboard.
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("drain", 128'(exp_q.size()), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
